// File: rtl/axi_hci_lite_slave.sv
// ----------------------------------------------------------------------------
// axi_hci_lite_slave
//
// AXI4-Lite slave register block for the S00_AXI port of the HCI sensor IP.
// Eight 32-bit words are decoded from s00_axi_awaddr/araddr[4:2]:
//   words 0-3 : software read/write (word 0 = control, word 1 = config)
//   words 4-7 : read-only sensor capture (last count, sample count,
//               running max, status)
// One write and one read may be outstanding; the two paths are independent.
//
// Ports
//   s00_axi_aclk / s00_axi_aresetn : clock, asynchronous active-low reset
//   s00_axi_aw* / w* / b*          : AXI4-Lite write address, data, response
//   s00_axi_ar* / r*               : AXI4-Lite read address, data
//   hci_count / hci_valid          : sensor count and its single-cycle strobe
//   ctrl_out / cfg_out             : registered copies of word 0 / word 1
// ----------------------------------------------------------------------------
module axi_hci_lite_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int SAMPLE_CNT_WIDTH   = 16
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  input  logic [31:0]                     hci_count,
  input  logic                            hci_valid,
  output logic [31:0]                     ctrl_out,
  output logic [31:0]                     cfg_out
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [SAMPLE_CNT_WIDTH-1:0] CNT_ONE = {{(SAMPLE_CNT_WIDTH-1){1'b0}}, 1'b1};

  // Write-path state
  logic        r_aw_held, r_w_held, r_bvalid;
  logic        r_awready, r_wready;
  logic [1:0]  r_bresp;
  logic [2:0]  r_aw_word;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;

  // Read-path state
  logic        r_arready, r_rvalid;
  logic [31:0] r_rdata;

  // Register file
  logic [31:0] r_ctl [0:3];
  logic [31:0] r_last;
  logic [SAMPLE_CNT_WIDTH-1:0] r_cnt;
  logic [31:0] r_max;

  // Combinational helpers
  logic        w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_clear, w_cnt_sat;
  logic [2:0]  w_wr_word;
  logic [31:0] w_wr_data;
  logic [3:0]  w_wr_strb;
  logic        w_aw_held_n, w_w_held_n, w_bvalid_n;
  logic [1:0]  w_bresp_n;
  logic        w_rvalid_n;
  logic [31:0] w_rd_word;
  logic        w_unused;

  assign w_unused = ^{s00_axi_awprot, s00_axi_arprot,
                      s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  assign w_aw_hs = s00_axi_awvalid && r_awready;
  assign w_w_hs  = s00_axi_wvalid  && r_wready;
  assign w_ar_hs = s00_axi_arvalid && r_arready;

  // A held beat and a same-cycle handshake are interchangeable for commit.
  assign w_commit  = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
  assign w_wr_word = w_aw_hs ? s00_axi_awaddr[4:2] : r_aw_word;
  assign w_wr_data = w_w_hs  ? s00_axi_wdata       : r_wdata;
  assign w_wr_strb = w_w_hs  ? s00_axi_wstrb       : r_wstrb;

  // Control bit 1 is a clear command for the sensor capture words.
  assign w_clear   = w_commit && (w_wr_word == 3'd0) && w_wr_strb[0] && w_wr_data[1];
  assign w_cnt_sat = &r_cnt;

  // Next-state for the write channel handshake/response tracking
  always_comb begin
    w_aw_held_n = r_aw_held;
    w_w_held_n  = r_w_held;
    w_bvalid_n  = r_bvalid;
    w_bresp_n   = r_bresp;
    if (w_commit) begin
      w_aw_held_n = 1'b0;
      w_w_held_n  = 1'b0;
      w_bvalid_n  = 1'b1;
      w_bresp_n   = w_wr_word[2] ? RESP_SLVERR : RESP_OKAY;
    end else begin
      if (w_aw_hs) begin
        w_aw_held_n = 1'b1;
      end else begin
        w_aw_held_n = r_aw_held;
      end
      if (w_w_hs) begin
        w_w_held_n = 1'b1;
      end else begin
        w_w_held_n = r_w_held;
      end
      if (r_bvalid && s00_axi_bready) begin
        w_bvalid_n = 1'b0;
      end else begin
        w_bvalid_n = r_bvalid;
      end
    end
  end

  // Write channel state and registered readies (held low while in reset)
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_aw_word <= 3'd0;
      r_wdata   <= 32'h0;
      r_wstrb   <= 4'h0;
    end else begin
      r_aw_held <= w_aw_held_n;
      r_w_held  <= w_w_held_n;
      r_bvalid  <= w_bvalid_n;
      r_bresp   <= w_bresp_n;
      r_awready <= !w_aw_held_n && !w_bvalid_n;
      r_wready  <= !w_w_held_n && !w_bvalid_n;
      if (w_aw_hs) begin
        r_aw_word <= s00_axi_awaddr[4:2];
      end
      if (w_w_hs) begin
        r_wdata <= s00_axi_wdata;
        r_wstrb <= s00_axi_wstrb;
      end
    end
  end

  // Software registers: byte-lane writes; control bit 1 lasts one cycle
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      for (int i = 0; i < 4; i++) begin
        r_ctl[i] <= 32'h0;
      end
    end else begin
      if (w_commit && !w_wr_word[2]) begin
        for (int b = 0; b < 4; b++) begin
          if (w_wr_strb[b]) begin
            r_ctl[w_wr_word[1:0]][b*8 +: 8] <= w_wr_data[b*8 +: 8];
          end
        end
      end
      if (!(w_commit && (w_wr_word == 3'd0))) begin
        r_ctl[0][1] <= 1'b0;
      end
    end
  end

  // Sensor capture: clear beats a coincident sample
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_last <= 32'h0;
      r_cnt  <= {SAMPLE_CNT_WIDTH{1'b0}};
      r_max  <= 32'h0;
    end else if (w_clear) begin
      r_last <= 32'h0;
      r_cnt  <= {SAMPLE_CNT_WIDTH{1'b0}};
      r_max  <= 32'h0;
    end else if (hci_valid && r_ctl[0][0]) begin
      r_last <= hci_count;
      if (!w_cnt_sat) begin
        r_cnt <= r_cnt + CNT_ONE;
      end
      if (hci_count > r_max) begin
        r_max <= hci_count;
      end
    end
  end

  // Read mux; control bit 1 is write-only and always reads back 0
  always_comb begin
    w_rd_word = 32'h0;
    case (s00_axi_araddr[4:2])
      3'd0:    w_rd_word = {r_ctl[0][31:2], 1'b0, r_ctl[0][0]};
      3'd1:    w_rd_word = r_ctl[1];
      3'd2:    w_rd_word = r_ctl[2];
      3'd3:    w_rd_word = r_ctl[3];
      3'd4:    w_rd_word = r_last;
      3'd5:    w_rd_word = {{(32-SAMPLE_CNT_WIDTH){1'b0}}, r_cnt};
      3'd6:    w_rd_word = r_max;
      3'd7:    w_rd_word = {30'h0, r_ctl[0][0], w_cnt_sat};
      default: w_rd_word = 32'h0;
    endcase
  end

  // Next-state for the read response valid
  always_comb begin
    w_rvalid_n = r_rvalid;
    if (w_ar_hs) begin
      w_rvalid_n = 1'b1;
    end else if (r_rvalid && s00_axi_rready) begin
      w_rvalid_n = 1'b0;
    end else begin
      w_rvalid_n = r_rvalid;
    end
  end

  // Read channel: capture data on AR handshake, hold until R handshake
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_rvalid  <= 1'b0;
      r_arready <= 1'b0;
      r_rdata   <= 32'h0;
    end else begin
      r_rvalid  <= w_rvalid_n;
      r_arready <= !w_rvalid_n;
      if (w_ar_hs) begin
        r_rdata <= w_rd_word;
      end
    end
  end

  assign s00_axi_awready = r_awready;
  assign s00_axi_wready  = r_wready;
  assign s00_axi_bvalid  = r_bvalid;
  assign s00_axi_bresp   = r_bresp;
  assign s00_axi_arready = r_arready;
  assign s00_axi_rvalid  = r_rvalid;
  assign s00_axi_rdata   = r_rdata;
  assign s00_axi_rresp   = RESP_OKAY;
  assign ctrl_out        = r_ctl[0];
  assign cfg_out         = r_ctl[1];

endmodule

// File: doc/axi_hci_lite_slave.md
Name: axi_hci_lite_slave

Overview:
- AXI4-Lite slave register block that terminates the S00_AXI interface of the 3-stage HCI sensor IP; it is the responder to the AXI4-Lite master issuing AXI4LITE_WRITE_BURST/READ_BURST traffic.
- Holds four software read/write registers at words 0-3, which drive sensor control and configuration.
- Holds four read-only registers at words 4-7, which capture the HCI sensor count and status.
- Accepts one outstanding write and one outstanding read. Write and read paths are independent.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 5, byte address width; 8 words; addr[1:0] ignored.
- SAMPLE_CNT_WIDTH, 16, width of the sensor sample counter.

Ports:
- s00_axi_aclk  in  1  clock
- s00_axi_aresetn  in  1  asynchronous active-low reset
- s00_axi_awaddr  in  5  write address
- s00_axi_awprot  in  3  ignored
- s00_axi_awvalid/awready  in/out  1  AW handshake
- s00_axi_wdata  in  32  write data
- s00_axi_wstrb  in  4  byte strobes
- s00_axi_wvalid/wready  in/out  1  W handshake
- s00_axi_bresp  out  2  write response
- s00_axi_bvalid/bready  out/in  1  B handshake
- s00_axi_araddr  in  5  read address
- s00_axi_arprot  in  3  ignored
- s00_axi_arvalid/arready  in/out  1  AR handshake
- s00_axi_rdata  out  32  read data
- s00_axi_rresp  out  2  read response
- s00_axi_rvalid/rready  out/in  1  R handshake
- hci_count  in  32  sensor ring-oscillator count
- hci_valid  in  1  single-cycle strobe; hci_count is valid this cycle
- ctrl_out  out  32  copy of reg0
- cfg_out  out  32  copy of reg1

Behaviour:
- Reset (async assert, sync release): every ready, bvalid and rvalid = 0; bresp = rresp = 0; rdata = 0; regs 0-7 = 0; ctrl_out = cfg_out = 0.
- Reset mid-transaction abandons it. No response is issued after reset.

Write path:
- State is aw_held, w_held, bvalid.
- awready = !aw_held && !bvalid. wready = !w_held && !bvalid.
- AW and W may arrive in either order or in the same cycle. Each is latched on its own handshake.
- Commit cycle: when both are held (or handshake together), the write commits in that cycle.
  - Words 0-3: each byte lane updates where wstrb[n]=1.
  - Words 4-7: no register change.
- Registers are visible to a read AR accepted on the next cycle.
- bvalid rises on the cycle after commit.
  - bresp = OKAY (00) for words 0-3.
  - bresp = SLVERR (10) for words 4-7.
- bvalid holds, with stable bresp, until bready. aw_held and w_held clear on commit.
- Next AW/W is not accepted while bvalid=1.
- Minimum write latency, AW/W handshake to bvalid: 1 cycle. Maximum throughput: one write per 2 cycles.

Read path:
- arready = !rvalid.
- On the AR handshake, rdata is registered with the word at araddr[4:2]; rvalid=1 on the next cycle. rresp = OKAY for all 8 words.
- rvalid holds, with stable rdata, until rready.
- A read of a word committed in the same cycle as the AR handshake returns the old value.

Read-only registers:
- reg4 = last hci_count, latched on hci_valid.
- reg5[SAMPLE_CNT_WIDTH-1:0] = count of hci_valid pulses.
  - Saturates at all-ones; it does not wrap.
  - Upper bits read 0.
- reg6 = running max of hci_count.
- reg7[0] = saturated flag (reg5 at max).
- reg7[1] = sensor enable, mirrors reg0[0].
- Upper bits of reg7 read 0.
- hci_valid is ignored when reg0[0]=0.
- Writing 1 to reg0[1] clears reg4-reg6 on the commit cycle. Bit 1 self-clears on the next cycle; reads return 0 afterwards.
- If a clear commits in the same cycle as an hci_valid, the clear wins.

Test Plan:
- Reset then idle -> all readys 0 during reset; after release awready=wready=arready=1, bvalid=rvalid=0; reads of words 0-7 return 0.
- Write 0x1,0x2,0x3,0x4 to addr 0x0,0x4,0x8,0xC with wstrb=F, then read back -> each bresp=OKAY; reads return 0x1..0x4, rresp=OKAY.
- W before AW by 3 cycles; then AW and W in the same cycle -> single commit each; bvalid one cycle after commit; wstrb=4'b0010 with data 0xAABBCCDD over 0x11111111 yields 0x1111CC11.
- Hold bready=0 and rready=0 for 5 cycles -> bvalid/rvalid and data stable; awready/wready/arready stay 0 until the response handshakes.
- reg0=0x1, pulse hci_valid with counts 100,50,300 -> reg4=300, reg5=3, reg6=300; write 0x3 to reg0 -> reg4-6=0, reg0 reads 0x1; write to 0x10 -> bresp=SLVERR, reg4 unchanged.
- Assert reset while bvalid=1 awaiting bready -> bvalid drops immediately; regs 0 after release; no stale response.
